// File: rtl/led_anim_gen_if.sv
// Game-state flags in, end-of-game LED patterns out, between the game FSM
// and the LEDR priority mux.
interface led_anim_gen_if;
    logic        senha_correta;
    logic        derrota;
    logic [17:0] leds_vitoria;
    logic [17:0] leds_derrota;
    logic        derrota_fim;

    modport master (
        output senha_correta,
        output derrota,
        input  leds_vitoria,
        input  leds_derrota,
        input  derrota_fim
    );

    modport slave (
        input  senha_correta,
        input  derrota,
        output leds_vitoria,
        output leds_derrota,
        output derrota_fim
    );
endinterface

// File: rtl/led_anim_gen.sv
// End-of-game LED animations: bouncing one-hot chaser on victory, 18-LED
// blink that settles solid on defeat, both stepped by a shared prescaler.
module led_anim_gen #(
    parameter int TICK_DIV = 12_500_000,
    parameter int BLINKS   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    led_anim_gen_if.slave anim_bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(2 * BLINKS + 1);
    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE    = PW'(1);
    localparam logic [CW-1:0] TOGGLES      = CW'(2 * BLINKS);
    localparam logic [CW-1:0] TOGGLES_LAST = CW'(2 * BLINKS - 1);
    localparam logic [CW-1:0] TOGGLE_ONE   = CW'(1);
    localparam logic [4:0]    POS_LAST     = 5'd17;

    typedef enum logic [1:0] {IDLE, WIN, LOSE} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [4:0]    r_pos;
    logic          r_dir_up;
    logic [CW-1:0] r_toggles;
    logic [17:0]   r_leds_vitoria;
    logic [17:0]   r_leds_derrota;
    logic          r_derrota_fim;

    logic          w_tick;
    logic [4:0]    w_pos_next;
    logic          w_dir_up_next;
    logic [17:0]   w_chase_next;

    assign w_tick        = (r_presc == PRESC_LAST);
    assign w_pos_next    = r_dir_up ? (r_pos + 5'd1) : (r_pos - 5'd1);
    // Turn around on arrival so each end position is shown for a single step.
    assign w_dir_up_next = (w_pos_next == POS_LAST) ? 1'b0 :
                           (w_pos_next == 5'd0)     ? 1'b1 : r_dir_up;

    genvar gi;
    generate
        for (gi = 0; gi < 18; gi++) begin : g_chase
            assign w_chase_next[gi] = (w_pos_next == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_presc        <= '0;
            r_pos          <= '0;
            r_dir_up       <= 1'b1;
            r_toggles      <= '0;
            r_leds_vitoria <= '0;
            r_leds_derrota <= '0;
            r_derrota_fim  <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : (r_presc + PRESC_ONE);
            case (r_state)
                IDLE: begin
                    r_presc        <= '0;
                    r_pos          <= '0;
                    r_dir_up       <= 1'b1;
                    r_toggles      <= '0;
                    r_leds_vitoria <= '0;
                    r_leds_derrota <= '0;
                    r_derrota_fim  <= 1'b0;
                    if (anim_bus.senha_correta) begin
                        r_state        <= WIN;
                        r_leds_vitoria <= 18'h00001;
                    end else if (anim_bus.derrota) begin
                        r_state        <= LOSE;
                        r_leds_derrota <= 18'h3FFFF;
                    end
                end
                WIN: begin
                    if (!anim_bus.senha_correta) begin
                        r_state        <= IDLE;
                        r_presc        <= '0;
                        r_pos          <= '0;
                        r_dir_up       <= 1'b1;
                        r_leds_vitoria <= '0;
                    end else if (w_tick) begin
                        r_pos          <= w_pos_next;
                        r_dir_up       <= w_dir_up_next;
                        r_leds_vitoria <= w_chase_next;
                    end
                end
                LOSE: begin
                    if (anim_bus.senha_correta) begin
                        r_state        <= WIN;
                        r_presc        <= '0;
                        r_pos          <= '0;
                        r_dir_up       <= 1'b1;
                        r_toggles      <= '0;
                        r_leds_vitoria <= 18'h00001;
                        r_leds_derrota <= '0;
                        r_derrota_fim  <= 1'b0;
                    end else if (!anim_bus.derrota) begin
                        r_state        <= IDLE;
                        r_presc        <= '0;
                        r_toggles      <= '0;
                        r_leds_derrota <= '0;
                        r_derrota_fim  <= 1'b0;
                    end else if (w_tick && (r_toggles != TOGGLES)) begin
                        r_leds_derrota <= ~r_leds_derrota;
                        r_toggles      <= r_toggles + TOGGLE_ONE;
                        r_derrota_fim  <= (r_toggles == TOGGLES_LAST);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign anim_bus.leds_vitoria = r_leds_vitoria;
    assign anim_bus.leds_derrota = r_leds_derrota;
    assign anim_bus.derrota_fim  = r_derrota_fim;
endmodule

// File: tb/tb_led_anim_gen.sv
// Randomized scoreboard bench for led_anim_gen: a cycle-age reference model
// queues the expected outputs per edge, a monitor compares on the falling edge.
module tb_led_anim_gen;
    localparam int TICK_DIV = 4;
    localparam int BLINKS   = 3;
    localparam int M_IDLE   = 0;
    localparam int M_WIN    = 1;
    localparam int M_LOSE   = 2;

    typedef struct packed {
        logic [17:0] vit;
        logic [17:0] der;
        logic        fim;
    } exp_t;

    logic clk;
    logic rst_n;
    logic senha;
    logic derrota;

    int checks = 0;
    int passes = 0;
    exp_t exp_q[$];
    int m_state = M_IDLE;
    int m_age   = 0;

    led_anim_gen_if bus ();
    assign bus.senha_correta = senha;
    assign bus.derrota       = derrota;

    led_anim_gen #(.TICK_DIV(TICK_DIV), .BLINKS(BLINKS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .anim_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs from the number of cycles spent in the current state.
    function automatic exp_t model_out(input int st, input int age);
        exp_t e;
        int steps, m, pos, t;
        e = '0;
        steps = age / TICK_DIV;
        if (st == M_WIN) begin
            m   = steps % 34;
            pos = (m <= 17) ? m : 34 - m;
            e.vit = 18'd1 << pos;
        end else if (st == M_LOSE) begin
            t = (steps < 2 * BLINKS) ? steps : 2 * BLINKS;
            e.der = (t % 2 == 0) ? 18'h3FFFF : 18'h00000;
            e.fim = (t == 2 * BLINKS);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %05h, expected %05h at %0t", name, act, req, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_IDLE;
            m_age   = 0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (senha) begin m_state = M_WIN; m_age = 0; end
                    else if (derrota) begin m_state = M_LOSE; m_age = 0; end
                end
                M_WIN: begin
                    if (!senha) m_state = M_IDLE;
                    else m_age++;
                end
                default: begin
                    if (senha) begin m_state = M_WIN; m_age = 0; end
                    else if (!derrota) m_state = M_IDLE;
                    else m_age++;
                end
            endcase
        end
        if (clk) exp_q.push_back(model_out(m_state, m_age));
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("leds_vitoria", bus.leds_vitoria, e.vit);
            chk("leds_derrota", bus.leds_derrota, e.der);
            chk("derrota_fim", {17'd0, bus.derrota_fim}, {17'd0, e.fim});
            $display("t=%0t s=%0b d=%0b vit=%05h der=%05h fim=%0b", $time,
                     senha, derrota, bus.leds_vitoria, bus.leds_derrota, bus.derrota_fim);
        end
    end

    task automatic drive(input logic s, input logic d, input int n);
        senha   = s;
        derrota = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vitoria", bus.leds_vitoria, 18'h0);
        chk("async_rst_derrota", bus.leds_derrota, 18'h0);
        chk("async_rst_fim", {17'd0, bus.derrota_fim}, 18'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        senha   = 1'b1;
        derrota = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, 40 * TICK_DIV + 2);   // victory bounce
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 40);                  // full defeat blink and hold
        drive(1'b1, 1'b1, 6);                   // victory overrides defeat
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b1, 10);                  // simultaneous from IDLE
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 9 * TICK_DIV + 2);    // drop at pos 9
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 10);                  // re-entry restarts chase
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 10);
        pulse_reset();                          // async reset mid-LOSE
        drive(1'b0, 1'b1, 30);
        for (int i = 0; i < 250; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 60));
            if ($urandom_range(0, 9) == 0) pulse_reset();
        end
        drive(1'b0, 1'b0, 3);
        @(negedge clk);
        #1;
        chk("queue_drained", 18'(exp_q.size()), 18'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
